// File: rtl/combat_arbiter.sv
// combat_arbiter: two-player attack/shield arbiter driving health and shield bookkeeping.
//   clk, reset            : clock, synchronous active-high reset
//   tick                  : one-cycle strobe from the slowed game clock
//   p1/p2_attack_req      : attack request levels (sampled only in IDLE)
//   p1/p2_shield_req      : shield held
//   in_range              : players overlap
//   p1/p2_health, _shield : 8-bit saturating registers, reset to MAX_VAL
//   p1/p2_hit             : one-cycle pulse after the player takes damage
//   busy, game_over       : not IDLE / in OVER
//   winner                : 00 none, 01 player 1, 10 player 2
module combat_arbiter #(
    parameter int WINDUP_TICKS   = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int DAMAGE         = 3,
    parameter int SHIELD_COST    = 2,
    parameter int MAX_VAL        = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       p1_attack_req,
    input  logic       p2_attack_req,
    input  logic       p1_shield_req,
    input  logic       p2_shield_req,
    input  logic       in_range,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic [7:0] p1_shield,
    output logic [7:0] p2_shield,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {IDLE, WINDUP, RESOLVE, COOLDOWN, OVER} state_t;

    localparam logic [15:0] WT  = 16'(WINDUP_TICKS);
    localparam logic [15:0] CT  = 16'(COOLDOWN_TICKS);
    localparam logic [7:0]  DMG = 8'(DAMAGE);
    localparam logic [7:0]  SC  = 8'(SHIELD_COST);
    localparam logic [7:0]  MV  = 8'(MAX_VAL);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic        att, att_n;          // 0: player 1 attacks, 1: player 2 attacks
    logic        prio_p2, prio_p2_n;  // round-robin priority holder for contested grants
    logic [7:0]  p1_health_n, p2_health_n, p1_shield_n, p2_shield_n;
    logic        p1_hit_n, p2_hit_n;
    logic [1:0]  winner_n;
    logic [7:0]  d_h, d_s, d_h_cut, d_s_cut, res_h;
    logic        shield_ok;

    assign busy      = state != IDLE;
    assign game_over = state == OVER;
    assign cnt_inc   = cnt + 16'd1;

    // Defender view, selected by the latched attacker
    assign d_h       = att ? p1_health : p2_health;
    assign d_s       = att ? p1_shield : p2_shield;
    assign shield_ok = (att ? p1_shield_req : p2_shield_req) && d_s != 8'd0;
    assign d_h_cut   = d_h > DMG ? d_h - DMG : 8'd0;
    assign d_s_cut   = d_s > SC ? d_s - SC : 8'd0;
    assign res_h     = (in_range && !shield_ok) ? d_h_cut : d_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            att       <= 1'b0;
            prio_p2   <= 1'b0;
            p1_health <= MV;
            p2_health <= MV;
            p1_shield <= MV;
            p2_shield <= MV;
            p1_hit    <= 1'b0;
            p2_hit    <= 1'b0;
            winner    <= 2'b00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            att       <= att_n;
            prio_p2   <= prio_p2_n;
            p1_health <= p1_health_n;
            p2_health <= p2_health_n;
            p1_shield <= p1_shield_n;
            p2_shield <= p2_shield_n;
            p1_hit    <= p1_hit_n;
            p2_hit    <= p2_hit_n;
            winner    <= winner_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        att_n       = att;
        prio_p2_n   = prio_p2;
        p1_health_n = p1_health;
        p2_health_n = p2_health;
        p1_shield_n = p1_shield;
        p2_shield_n = p2_shield;
        p1_hit_n    = 1'b0;
        p2_hit_n    = 1'b0;
        winner_n    = winner;
        case (state)
            IDLE: begin
                if (p1_attack_req || p2_attack_req) begin
                    // Contested: priority holder wins; either way priority moves to the loser
                    att_n     = p1_attack_req ? (p2_attack_req & prio_p2) : 1'b1;
                    prio_p2_n = ~att_n;
                    cnt_n     = '0;
                    state_n   = WINDUP;
                end
            end
            WINDUP: begin
                if (tick) begin
                    cnt_n   = cnt_inc;
                    state_n = cnt_inc >= WT ? RESOLVE : WINDUP;
                end
            end
            RESOLVE: begin
                if (in_range && shield_ok) begin
                    if (att) p1_shield_n = d_s_cut;
                    else     p2_shield_n = d_s_cut;
                end else if (in_range) begin
                    if (att) begin
                        p1_health_n = d_h_cut;
                        p1_hit_n    = 1'b1;
                    end else begin
                        p2_health_n = d_h_cut;
                        p2_hit_n    = 1'b1;
                    end
                end
                cnt_n    = '0;
                state_n  = res_h == 8'd0 ? OVER : COOLDOWN;
                winner_n = res_h == 8'd0 ? (att ? 2'b10 : 2'b01) : winner;
            end
            COOLDOWN: begin
                if (tick) begin
                    cnt_n   = cnt_inc;
                    state_n = cnt_inc >= CT ? IDLE : COOLDOWN;
                end
            end
            OVER: state_n = OVER;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_combat_arbiter.sv
// tb_combat_arbiter: vector table, directed corner sequences and random run against a phase/countdown model.
module tb_combat_arbiter;
    localparam int WT = 4, CT = 8, DMG = 3, SC = 2;
    localparam int PH_IDLE = 0, PH_WIND = 1, PH_RES = 2, PH_COOL = 3, PH_OVER = 4;

    logic clk = 1'b0;
    logic reset, tick, p1_attack_req, p2_attack_req, p1_shield_req, p2_shield_req, in_range;
    logic [7:0] p1_health, p2_health, p1_shield, p2_shield;
    logic p1_hit, p2_hit, busy, game_over;
    logic [1:0] winner;
    logic [7:0] b_p1_health, b_p2_health, b_p1_shield, b_p2_shield;
    logic b_p1_hit, b_p2_hit, b_busy, b_game_over;
    logic [1:0] b_winner;

    int total = 0, bad = 0;
    int m_ph, m_left, m_pr, m_a, m_win;
    int m_h[3], m_s[3], m_hit[3];
    logic seen1, seen2;

    always #5 clk = ~clk;

    combat_arbiter dut (
        .clk(clk), .reset(reset), .tick(tick),
        .p1_attack_req(p1_attack_req), .p2_attack_req(p2_attack_req),
        .p1_shield_req(p1_shield_req), .p2_shield_req(p2_shield_req),
        .in_range(in_range),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_shield(p1_shield), .p2_shield(p2_shield),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .busy(busy), .game_over(game_over), .winner(winner)
    );

    // Heavy-hitting, fast variant: 15 -> 2 -> 0 exercises saturation below DAMAGE
    combat_arbiter #(.WINDUP_TICKS(1), .COOLDOWN_TICKS(1), .DAMAGE(13)) dut_b (
        .clk(clk), .reset(reset), .tick(tick),
        .p1_attack_req(p1_attack_req), .p2_attack_req(p2_attack_req),
        .p1_shield_req(p1_shield_req), .p2_shield_req(p2_shield_req),
        .in_range(in_range),
        .p1_health(b_p1_health), .p2_health(b_p2_health),
        .p1_shield(b_p1_shield), .p2_shield(b_p2_shield),
        .p1_hit(b_p1_hit), .p2_hit(b_p2_hit),
        .busy(b_busy), .game_over(b_game_over), .winner(b_winner)
    );

    typedef struct {
        logic       r1, tk, rng;
        logic       busy;
        logic [7:0] h2;
        logic       hit2;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(logic r1, logic tk, logic rng, logic b, logic [7:0] h2, logic hit2);
        vec_t v;
        v.r1 = r1; v.tk = tk; v.rng = rng; v.busy = b; v.h2 = h2; v.hit2 = hit2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v < 0 ? 0 : v;
    endfunction

    // Reference behaviour for one clock edge, using the inputs present at that edge
    task automatic model_edge();
        int d;
        if (reset) begin
            m_ph = PH_IDLE; m_pr = 1; m_win = 0; m_left = 0;
            for (int i = 1; i <= 2; i++) begin m_h[i] = 15; m_s[i] = 15; m_hit[i] = 0; end
            return;
        end
        m_hit[1] = 0; m_hit[2] = 0;
        case (m_ph)
            PH_IDLE: if (p1_attack_req || p2_attack_req) begin
                m_a = (p1_attack_req && p2_attack_req) ? m_pr : (p1_attack_req ? 1 : 2);
                m_pr = 3 - m_a; m_left = WT; m_ph = PH_WIND;
            end
            PH_WIND: if (tick) begin m_left--; if (m_left == 0) m_ph = PH_RES; end
            PH_RES: begin
                d = 3 - m_a;
                if (in_range) begin
                    if ((d == 1 ? p1_shield_req : p2_shield_req) && m_s[d] > 0) m_s[d] = sat(m_s[d] - SC);
                    else begin m_h[d] = sat(m_h[d] - DMG); m_hit[d] = 1; end
                end
                if (m_h[d] == 0) begin m_ph = PH_OVER; m_win = m_a; end
                else begin m_ph = PH_COOL; m_left = CT; end
            end
            PH_COOL: if (tick) begin m_left--; if (m_left == 0) m_ph = PH_IDLE; end
            default: ;
        endcase
    endtask

    task automatic step();
        logic [37:0] exp;
        @(posedge clk);
        #1;
        model_edge();
        exp = {8'(m_h[1]), 8'(m_h[2]), 8'(m_s[1]), 8'(m_s[2]), m_hit[1] != 0, m_hit[2] != 0,
               m_ph != PH_IDLE, m_ph == PH_OVER, 2'(m_win)};
        chk("model", {p1_health, p2_health, p1_shield, p2_shield, p1_hit, p2_hit, busy, game_over, winner}, exp);
        seen1 |= p1_hit;
        seen2 |= p2_hit;
    endtask

    task automatic clr();
        p1_attack_req = 0; p2_attack_req = 0; p1_shield_req = 0; p2_shield_req = 0;
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    initial begin
        reset = 1; tick = 0; in_range = 0; clr();
        seen1 = 0; seen2 = 0;
        tbl[0]  = mk(1, 1, 1, 1, 15, 0);
        tbl[1]  = mk(0, 1, 1, 1, 15, 0);
        tbl[2]  = mk(0, 1, 1, 1, 15, 0);
        tbl[3]  = mk(0, 1, 1, 1, 15, 0);
        tbl[4]  = mk(0, 1, 1, 1, 15, 0);
        tbl[5]  = mk(0, 1, 1, 1, 12, 1);
        tbl[6]  = mk(0, 1, 1, 1, 12, 0);
        tbl[7]  = mk(0, 1, 1, 1, 12, 0);
        tbl[8]  = mk(0, 1, 1, 1, 12, 0);
        tbl[9]  = mk(0, 1, 1, 1, 12, 0);
        tbl[10] = mk(0, 1, 1, 1, 12, 0);
        tbl[11] = mk(0, 1, 1, 1, 12, 0);
        tbl[12] = mk(0, 1, 1, 1, 12, 0);
        tbl[13] = mk(0, 1, 1, 0, 12, 0);

        do_reset();
        chk("rst_health", {p1_health, p2_health}, {8'd15, 8'd15});
        chk("rst_shield", {p1_shield, p2_shield}, {8'd15, 8'd15});
        chk("rst_flags", {p1_hit, p2_hit, busy, game_over, winner}, 6'b0);

        // Solo hit
        for (int i = 0; i < 14; i++) begin
            p1_attack_req = tbl[i].r1; tick = tbl[i].tk; in_range = tbl[i].rng;
            step();
            chk($sformatf("solo_busy[%0d]", i), busy, tbl[i].busy);
            chk($sformatf("solo_h2[%0d]", i), p2_health, tbl[i].h2);
            chk($sformatf("solo_hit2[%0d]", i), p2_hit, tbl[i].hit2);
        end

        // Shielded block
        do_reset(); clr(); tick = 1; in_range = 1;
        p2_attack_req = 1; p1_shield_req = 1; step(); p2_attack_req = 0;
        seen1 = 0;
        repeat (5) step();
        chk("shield_s1", p1_shield, 13);
        chk("shield_h1", p1_health, 15);
        chk("shield_nohit", seen1, 0);
        repeat (8) step();
        chk("shield_idle", busy, 0);

        // Simultaneous requests: p1 first, then p2
        do_reset(); clr(); tick = 1; in_range = 1;
        p1_attack_req = 1; p2_attack_req = 1; step(); clr();
        repeat (13) step();
        chk("rr1", {p1_health, p2_health}, {8'd15, 8'd12});
        p1_attack_req = 1; p2_attack_req = 1; step(); clr();
        repeat (13) step();
        chk("rr2", {p1_health, p2_health}, {8'd12, 8'd12});

        // Out of range
        do_reset(); clr(); tick = 1; in_range = 0;
        p1_attack_req = 1; step(); p1_attack_req = 0;
        seen2 = 0;
        repeat (5) step();
        chk("oor_vals", {p1_health, p2_health, p1_shield, p2_shield}, {4{8'd15}});
        chk("oor_nohit", seen2, 0);
        chk("oor_cool", busy, 1);
        repeat (8) step();
        chk("oor_idle", busy, 0);

        // Reset mid-WINDUP, with a request held during reset
        do_reset(); clr(); tick = 1; in_range = 1;
        p1_attack_req = 1; step(); p1_attack_req = 0;
        step(); step();
        reset = 1; p2_attack_req = 1; step(); reset = 0; p2_attack_req = 0;
        chk("rstw_busy", busy, 0);
        chk("rstw_win", winner, 0);
        chk("rstw_h", {p1_health, p2_health}, {8'd15, 8'd15});

        // KO with saturation, then absorbing OVER
        do_reset(); clr(); tick = 1; in_range = 1;
        p1_attack_req = 1;
        repeat (70) step();
        chk("ko_h2", p2_health, 0);
        chk("ko_over", game_over, 1);
        chk("ko_win", winner, 2'b01);
        chk("ko_h1", p1_health, 15);
        chk("ko_b_h2", b_p2_health, 0);
        chk("ko_b_over", {b_game_over, b_winner}, 3'b101);
        p2_attack_req = 1; p1_shield_req = 1; p2_shield_req = 1;
        repeat (20) step();
        chk("over_hold", {p1_health, p2_health, p1_shield, p2_shield}, {8'd15, 8'd0, 8'd15, 8'd15});
        chk("over_win", {game_over, winner, busy}, 4'b1011);

        // Reset in OVER
        clr(); reset = 1; step(); reset = 0;
        chk("rsto_flags", {busy, game_over, winner}, 4'b0);
        chk("rsto_vals", {p1_health, p2_health, p1_shield, p2_shield}, {4{8'd15}});
        chk("rsto_b", {b_game_over, b_p2_health}, {1'b0, 8'd15});

        // Random run against the model
        for (int i = 0; i < 4000; i++) begin
            reset = $urandom_range(0, 799) == 0;
            p1_attack_req = $urandom_range(0, 5) == 0;
            p2_attack_req = $urandom_range(0, 5) == 0;
            p1_shield_req = $urandom_range(0, 2) == 0;
            p2_shield_req = $urandom_range(0, 2) == 0;
            in_range = $urandom_range(0, 3) != 0;
            tick = $urandom_range(0, 1) == 1;
            step();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/combat_arbiter.md
COMBAT_ARBITER -- requirements
Module: combat_arbiter

Interface
REQ-001 The block SHALL expose these parameters, one per line as name, default, meaning:
  WINDUP_TICKS, 4, tick strobes spent in WINDUP before a hit resolves.
  COOLDOWN_TICKS, 8, tick strobes spent in COOLDOWN after a resolve.
  DAMAGE, 3, health removed from an unshielded defender.
  SHIELD_COST, 2, shield removed from a shielding defender.
  MAX_VAL, 15, reset value of every health and shield register.
REQ-002 The block SHALL expose these ports, one per line as name, direction, width, meaning:
  clk  in  1  system clock.
  reset  in  1  synchronous, active-high reset.
  tick  in  1  one-cycle timer strobe from the slowed game clock.
  p1_attack_req  in  1  player 1 attack request level.
  p2_attack_req  in  1  player 2 attack request level.
  p1_shield_req  in  1  player 1 shield held.
  p2_shield_req  in  1  player 2 shield held.
  in_range  in  1  AABB collision (players overlap) from the game datapath.
  p1_health  out  8  player 1 health.
  p2_health  out  8  player 2 health.
  p1_shield  out  8  player 1 shield.
  p2_shield  out  8  player 2 shield.
  p1_hit  out  1  one-cycle pulse when player 1 takes damage.
  p2_hit  out  1  one-cycle pulse when player 2 takes damage.
  busy  out  1  high in every state except IDLE.
  game_over  out  1  high in OVER.
  winner  out  2  00 none, 01 player 1, 10 player 2.
REQ-003 There SHALL be exactly one clock and one reset; reset is synchronous and active-high, named clk and reset.

Function
REQ-004 The FSM SHALL have the states IDLE, WINDUP, RESOLVE, COOLDOWN and OVER.
REQ-005 In IDLE, a sampled attack request SHALL latch the attacker and defender, clear the tick counter and enter WINDUP on the next clk edge.
REQ-006 When both attack requests are high in IDLE in the same cycle, the grant SHALL go to the player holding round-robin priority.
- Priority then passes to the other player.
- A single uncontested request SHALL also pass priority to the other player.
REQ-007 Attack requests arriving in any state other than IDLE SHALL be ignored and not queued.
REQ-008 WINDUP timing:
- The counter SHALL increment only on cycles with tick=1.
- When the counter reaches WINDUP_TICKS, the FSM SHALL enter RESOLVE on that edge.
- tick=0 SHALL hold the counter.
REQ-009 RESOLVE SHALL last exactly one clk cycle and evaluate in_range and the defender's shield request in that cycle.
REQ-010 Resolve outcomes:
- in_range=0: no register changes.
- in_range=1, defender shield_req=1 and defender shield>0: defender shield -= min(SHIELD_COST, shield); health unchanged; no hit pulse.
- Otherwise (in range, no usable shield): defender health -= min(DAMAGE, health), and the defender hit output pulses for exactly the following cycle.
REQ-011 All arithmetic SHALL saturate at 0. No health or shield register may underflow or wrap.
REQ-012 After RESOLVE:
- If defender health is 0, the FSM SHALL go to OVER and set winner to the attacker.
- Otherwise it SHALL go to COOLDOWN with the counter cleared.
REQ-013 COOLDOWN SHALL count COOLDOWN_TICKS tick strobes, as in REQ-008, then return to IDLE.
REQ-014 OVER SHALL be absorbing until reset:
- game_over=1.
- winner held.
- All requests ignored.
- Health and shield frozen.
REQ-015 A tick coincident with a state entry SHALL NOT count toward the new state's counter.

Reset
REQ-016 When reset=1 at a clk edge, the following SHALL hold on that edge regardless of state, including mid-WINDUP, mid-COOLDOWN and OVER:
- FSM goes to IDLE.
- Counter is 0.
- Round-robin priority goes to player 1.
- All health and shield registers are MAX_VAL (15).
- p1_hit, p2_hit, busy, game_over are 0; winner is 00.
REQ-017 While reset=1, all requests SHALL be ignored.

Verification
REQ-018 Solo hit: p1_attack_req for 1 cycle, in_range=1, no shields, ticks every cycle. Required: busy rises the next cycle; RESOLVE after 4 ticks; p2_health 15->12; one p2_hit pulse; IDLE after 8 more ticks.
REQ-019 Shielded block: p2 attacks, p1_shield_req=1, in_range=1. Required: p1_shield 15->13, p1_health stays 15, no p1_hit.
REQ-020 Simultaneous requests: both attack requests high in the same IDLE cycle, twice in succession after reset. Required: player 1 is granted first, then player 2.
REQ-021 Saturation and KO: p2_health preloaded to 2 via prior hits, p1 hits in range. Required: p2_health 0; game_over=1; winner=01; further requests ignored.
REQ-022 Out of range: attack with in_range=0 at RESOLVE. Required: all health and shield unchanged; no pulse; COOLDOWN entered.
REQ-023 Reset mid-WINDUP and in OVER: assert reset for 1 cycle. Required: IDLE, all values 15, busy=0, winner=00 on the next cycle.
